// File: rtl/sha256_feeder.sv
// SHA-256 message feeder: buffers and pads a 32-bit big-endian word stream into
// 512-bit blocks, streams them to a serial hash core and collects the 8-word digest.
`timescale 1ns/1ps

module sha256_feeder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_word,
  input  logic        msg_last,
  input  logic [2:0]  msg_last_bytes,
  output logic        core_rst_n,
  output logic        calcu_en,
  input  logic        calcu_rdy,
  output logic        read_en,
  output logic [31:0] core_word,
  input  logic [31:0] core_digest,
  output logic        dig_valid,
  output logic [31:0] dig_word,
  output logic [2:0]  dig_index,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_FILL, S_PAD, S_SEND, S_WAIT, S_READ, S_DONE
  } state_t;

  state_t      state;
  logic [4:0]  idx;        // next buffer word to write, 16 = block full
  logic [63:0] bit_cnt;
  logic        need_80;    // last word was full, 0x80 marker still owed
  logic        two_blk;    // marker landed in word 14/15, length needs its own block
  logic        last_seen;
  logic [3:0]  cnt;        // shared step counter for CRST, SEND and READ

  logic [31:0] blk_buf [16];

  logic        accept;
  logic [2:0]  eff_lb;
  logic [31:0] last_word;
  logic        buf_we;
  logic [31:0] buf_wdata;

  assign msg_ready = (state == S_FILL) && !idx[4];
  assign busy      = (state != S_IDLE);
  assign accept    = msg_valid && msg_ready;
  assign eff_lb    = (msg_last_bytes > 3'd4) ? 3'd4 : msg_last_bytes;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    last_word = msg_word;
    case (eff_lb)
      3'd0:    last_word = 32'h8000_0000;
      3'd1:    last_word = {msg_word[31:24], 24'h80_0000};
      3'd2:    last_word = {msg_word[31:16], 16'h8000};
      3'd3:    last_word = {msg_word[31:8],  8'h80};
      default: last_word = msg_word;
    endcase
  end

  always_comb begin
    buf_we    = 1'b0;
    buf_wdata = '0;
    if (accept) begin
      buf_we    = 1'b1;
      buf_wdata = msg_last ? last_word : msg_word;
    end else if (state == S_PAD && !idx[4]) begin
      buf_we = 1'b1;
      if (need_80)
        buf_wdata = 32'h8000_0000;
      else if (idx >= 5'd14 && !two_blk)
        buf_wdata = idx[0] ? bit_cnt[31:0] : bit_cnt[63:32];
    end
  end

  // NOTE: the block buffer has no reset; every word is rewritten before a block is sent.
  always_ff @(posedge clk) begin
    if (buf_we) blk_buf[idx[3:0]] <= buf_wdata;
  end

  // NOTE: all state below uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      bit_cnt    <= '0;
      need_80    <= 1'b0;
      two_blk    <= 1'b0;
      last_seen  <= 1'b0;
      cnt        <= '0;
      core_rst_n <= 1'b0;
      calcu_en   <= 1'b0;
      read_en    <= 1'b0;
      core_word  <= '0;
      dig_valid  <= 1'b0;
      dig_word   <= '0;
      dig_index  <= '0;
    end else begin
      core_rst_n <= 1'b1;
      calcu_en   <= 1'b0;
      dig_valid  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (msg_valid) begin
            state      <= S_CRST;
            core_rst_n <= 1'b0;
            cnt        <= '0;
            idx        <= '0;
            bit_cnt    <= '0;
            need_80    <= 1'b0;
            two_blk    <= 1'b0;
            last_seen  <= 1'b0;
          end
        end

        S_CRST: begin
          if (cnt == 4'd1) begin
            state <= S_FILL;
          end else begin
            cnt        <= cnt + 4'd1;
            core_rst_n <= 1'b0;
          end
        end

        S_FILL: begin
          if (idx[4]) begin
            state     <= S_SEND;
            calcu_en  <= 1'b1;
            core_word <= blk_buf[0];
            cnt       <= '0;
          end else if (accept) begin
            idx <= idx + 5'd1;
            if (msg_last) begin
              bit_cnt   <= bit_cnt + {58'd0, eff_lb, 3'b000};
              last_seen <= 1'b1;
              need_80   <= (eff_lb == 3'd4);
              two_blk   <= (eff_lb != 3'd4) && (idx >= 5'd14);
              state     <= S_PAD;
            end else begin
              bit_cnt <= bit_cnt + 64'd32;
            end
          end
        end

        S_PAD: begin
          if (idx[4]) begin
            state     <= S_SEND;
            calcu_en  <= 1'b1;
            core_word <= blk_buf[0];
            cnt       <= '0;
          end else begin
            idx <= idx + 5'd1;
            if (need_80) begin
              need_80 <= 1'b0;
              if (idx >= 5'd14) two_blk <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (cnt == 4'd15) begin
            state     <= S_WAIT;
            core_word <= '0;
          end else begin
            core_word <= blk_buf[cnt + 4'd1];
            cnt       <= cnt + 4'd1;
          end
        end

        S_WAIT: begin
          if (calcu_rdy) begin
            idx <= '0;
            if (!last_seen) begin
              state <= S_FILL;
            end else if (two_blk || need_80) begin
              state   <= S_PAD;
              two_blk <= 1'b0;
            end else begin
              state   <= S_READ;
              read_en <= 1'b1;
              cnt     <= '0;
            end
          end
        end

        S_READ: begin
          // Core answers one cycle after each read_en; capture steps 1..8, show them a cycle later.
          cnt     <= cnt + 4'd1;
          read_en <= (cnt < 4'd7);
          if (cnt >= 4'd1 && cnt <= 4'd8) begin
            dig_valid <= 1'b1;
            dig_word  <= core_digest;
            dig_index <= 3'(cnt - 4'd1);
          end
          if (cnt == 4'd9) state <= S_DONE;
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_feeder.sv
// Self-checking bench for sha256_feeder: a SHA-256 hash-core model plus a byte-level
// padding reference; checks streamed blocks, digest readout, and reset behaviour.
`timescale 1ns/1ps

module tb_sha256_feeder;

  typedef byte unsigned bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        msg_valid = 1'b0;
  logic        msg_ready;
  logic [31:0] msg_word = '0;
  logic        msg_last = 1'b0;
  logic [2:0]  msg_last_bytes = '0;
  logic        core_rst_n;
  logic        calcu_en;
  logic        calcu_rdy;
  logic        read_en;
  logic [31:0] core_word;
  logic [31:0] core_digest;
  logic        dig_valid;
  logic [31:0] dig_word;
  logic [2:0]  dig_index;
  logic        busy;

  always #5 clk = ~clk;

  sha256_feeder dut (
    .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_word(msg_word), .msg_last(msg_last), .msg_last_bytes(msg_last_bytes),
    .core_rst_n(core_rst_n), .calcu_en(calcu_en), .calcu_rdy(calcu_rdy),
    .read_en(read_en), .core_word(core_word), .core_digest(core_digest),
    .dig_valid(dig_valid), .dig_word(dig_word), .dig_index(dig_index), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-7] + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    {a, b, c, d, e, f, g, hh} = h;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Hash-core model: takes 16 words starting at calcu_en, compresses, replies after a random delay.
  logic [511:0] got_q [$];
  logic [34:0]  dig_q [$];
  logic [511:0] cur;
  logic [255:0] hst;
  int wcnt = -1;
  int dly = -1;
  int ridx = 0;
  int stray = 0;
  int n_reads = 0;

  always @(posedge clk) begin
    if (!core_rst_n) begin
      hst = IV;
      wcnt = -1;
      dly = -1;
      ridx = 0;
      calcu_rdy <= 1'b0;
      core_digest <= '0;
    end else begin
      calcu_rdy <= 1'b0;
      if (calcu_en) begin
        cur[511:480] = core_word;
        wcnt = 1;
      end else if (wcnt > 0) begin
        cur[511 - 32*wcnt -: 32] = core_word;
        wcnt++;
        if (wcnt == 16) begin
          got_q.push_back(cur);
          hst = compress(hst, cur);
          wcnt = -1;
          dly = $urandom_range(0, 4);
        end
      end else if (core_word != 32'd0) begin
        stray++;
      end
      if (dly == 0) begin
        calcu_rdy <= 1'b1;
        dly = -1;
      end else if (dly > 0) begin
        dly--;
      end
      if (read_en) begin
        n_reads++;
        if (ridx < 8) core_digest <= hst[255 - 32*ridx -: 32];
        ridx++;
      end
    end
  end

  always @(negedge clk) begin
    if (dig_valid) dig_q.push_back({dig_index, dig_word});
  end

  task automatic send_word(input logic [31:0] w, input bit last, input logic [2:0] lb, output bit ok);
    int t = 0;
    msg_valid = 1'b1;
    msg_word = w;
    msg_last = last;
    msg_last_bytes = lb;
    while (!msg_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    ok = msg_ready;
    if (!ok) check("msg_ready timeout", 64'(msg_ready), 64'd1);
    else @(negedge clk);
    msg_valid = 1'b0;
    msg_last = 1'b0;
    msg_word = $urandom;
  endtask

  task automatic run_msg(input string name, input bq_t m, input bit gaps,
                         input bit has_ref, input logic [255:0] ref_dig);
    bq_t p;
    logic [511:0] exp_blk [$];
    logic [511:0] blk;
    logic [255:0] h;
    logic [63:0] bl;
    logic [31:0] w;
    logic [2:0] lb;
    int len, nw, nb0, nd0, ns0, nr0, t, ng, nd;
    bit ok, last;

    len = m.size();
    bl = 64'(len) * 64'd8;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    h = IV;
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
      exp_blk.push_back(blk);
      h = compress(h, blk);
    end

    @(negedge clk);
    nb0 = got_q.size(); nd0 = dig_q.size(); ns0 = stray; nr0 = n_reads;
    nw = (len == 0) ? 1 : (len + 3) / 4;
    ok = 1'b1;
    for (int wi = 0; wi < nw && ok; wi++) begin
      for (int j = 0; j < 4; j++)
        w[31 - 8*j -: 8] = (4*wi + j < len) ? m[4*wi + j] : 8'($urandom);
      last = (wi == nw - 1);
      lb = last ? 3'(len - 4*wi) : 3'($urandom_range(0, 4));
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_word(w, last, lb, ok);
    end

    t = 0;
    while (dig_q.size() - nd0 < 8 && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    nd = dig_q.size() - nd0;
    check({name, " digest count"}, 64'(nd), 64'd8);
    @(negedge clk); #1;
    check({name, " done busy"}, 64'(busy), 64'd1);
    @(negedge clk); #1;
    check({name, " idle busy"}, 64'(busy), 64'd0);
    check({name, " idle ready"}, 64'(msg_ready), 64'd0);
    check({name, " idle core_rst_n"}, 64'(core_rst_n), 64'd1);

    ng = got_q.size() - nb0;
    check({name, " block count"}, 64'(ng), 64'(exp_blk.size()));
    for (int b = 0; b < ng && b < exp_blk.size(); b++)
      for (int j = 0; j < 16; j++)
        check($sformatf("%s blk%0d w%0d", name, b, j),
              64'(got_q[nb0 + b][511 - 32*j -: 32]), 64'(exp_blk[b][511 - 32*j -: 32]));
    for (int i = 0; i < nd && i < 8; i++) begin
      check($sformatf("%s dig_index %0d", name, i), 64'(dig_q[nd0 + i][34:32]), 64'(i));
      check($sformatf("%s dig_word %0d", name, i), 64'(dig_q[nd0 + i][31:0]), 64'(h[255 - 32*i -: 32]));
      if (has_ref)
        check($sformatf("%s known dig %0d", name, i), 64'(dig_q[nd0 + i][31:0]), 64'(ref_dig[255 - 32*i -: 32]));
    end
    check({name, " core_word outside SEND"}, 64'(stray - ns0), 64'd0);
    check({name, " read_en cycles"}, 64'(n_reads - nr0), 64'd8);
  endtask

  localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_56    = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  task automatic check_reset_outputs(input string tag);
    check({tag, " msg_ready"}, 64'(msg_ready), 64'd0);
    check({tag, " calcu_en"}, 64'(calcu_en), 64'd0);
    check({tag, " read_en"}, 64'(read_en), 64'd0);
    check({tag, " core_word"}, 64'(core_word), 64'd0);
    check({tag, " dig_valid"}, 64'(dig_valid), 64'd0);
    check({tag, " dig_word"}, 64'(dig_word), 64'd0);
    check({tag, " dig_index"}, 64'(dig_index), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " core_rst_n"}, 64'(core_rst_n), 64'd0);
  endtask

  initial begin
    string s56;
    bq_t m;
    bit ok;
    int t, seen;
    int lens [8] = '{52, 53, 60, 61, 63, 64, 100, 120};

    s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset core_rst_n", 64'(core_rst_n), 64'd1);

    run_msg("abc", str2q("abc"), 1'b0, 1'b1, D_ABC);
    m.delete();
    run_msg("empty", m, 1'b0, 1'b1, D_EMPTY);
    run_msg("nist56", str2q(s56), 1'b0, 1'b1, D_56);
    run_msg("prefix55", str2q(s56.substr(0, 54)), 1'b0, 1'b0, '0);
    run_msg("prefix55 gaps", str2q(s56.substr(0, 54)), 1'b1, 1'b0, '0);
    run_msg("nist56 gaps", str2q(s56), 1'b1, 1'b1, D_56);
    foreach (lens[i]) begin
      m.delete();
      for (int j = 0; j < lens[i]; j++) m.push_back(8'($urandom));
      run_msg($sformatf("len%0d", lens[i]), m, 1'b1, 1'b0, '0);
    end
    for (int r = 0; r < 5; r++) begin
      m.delete();
      repeat ($urandom_range(0, 150)) m.push_back(8'($urandom));
      run_msg($sformatf("rand%0d len%0d", r, m.size()), m, 1'($urandom_range(0, 1)), 1'b0, '0);
    end

    // Abort in the middle of a SEND burst, then hash again from scratch.
    @(negedge clk);
    send_word(32'h61626300, 1'b1, 3'd3, ok);
    t = 0;
    while (!calcu_en && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("abort saw calcu_en", 64'(calcu_en), 64'd1);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (calcu_en || dig_valid || read_en) seen++;
    end
    check("abort quiet", 64'(seen), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort busy", 64'(busy), 64'd0);
    check("abort core_rst_n", 64'(core_rst_n), 64'd1);
    run_msg("abc after abort", str2q("abc"), 1'b0, 1'b1, D_ABC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
